// File: rtl/colorbar_mode_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : colorbar_mode_pkg
//  Description : Shared types for the colour-bar mode sequencer. Holds the
//                FSM state encoding, the mode codes and the timing preset
//                table for the three supported video modes.
//  Revision    : 1.0 - initial release
// ============================================================================
package colorbar_mode_pkg;

    // Sequencer states, explicitly encoded on two bits
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        SWITCH = 2'd3
    } state_t;

    // Mode codes as seen on req_mode / cur_mode
    localparam logic [1:0] c_mode_720p    = 2'd0;
    localparam logic [1:0] c_mode_1080p   = 2'd1;
    localparam logic [1:0] c_mode_480p    = 2'd2;
    localparam logic [1:0] c_mode_illegal = 2'd3;

    // Every preset value fits in 12 bits (largest is 2200)
    localparam int c_cfg_field_w = 12;

    typedef struct packed {
        logic [c_cfg_field_w-1:0] h_active;
        logic [c_cfg_field_w-1:0] h_total;
        logic [c_cfg_field_w-1:0] v_active;
        logic [c_cfg_field_w-1:0] v_total;
        logic [c_cfg_field_w-1:0] h_fp;
        logic [c_cfg_field_w-1:0] h_sync;
        logic [c_cfg_field_w-1:0] h_bp;
        logic [c_cfg_field_w-1:0] v_fp;
        logic [c_cfg_field_w-1:0] v_sync;
    } timing_cfg_t;

    // Timing preset table; the illegal code falls back to the 720p preset
    function automatic timing_cfg_t preset_cfg(input logic [1:0] mode);
        timing_cfg_t cfg;
        case (mode)
            c_mode_1080p: cfg = '{h_active: 12'd1920, h_total: 12'd2200,
                                  v_active: 12'd1080, v_total: 12'd1125,
                                  h_fp: 12'd88, h_sync: 12'd44, h_bp: 12'd148,
                                  v_fp: 12'd4, v_sync: 12'd5};
            c_mode_480p:  cfg = '{h_active: 12'd640, h_total: 12'd800,
                                  v_active: 12'd480, v_total: 12'd525,
                                  h_fp: 12'd16, h_sync: 12'd96, h_bp: 12'd48,
                                  v_fp: 12'd10, v_sync: 12'd2};
            default:      cfg = '{h_active: 12'd1280, h_total: 12'd1650,
                                  v_active: 12'd720, v_total: 12'd750,
                                  h_fp: 12'd110, h_sync: 12'd40, h_bp: 12'd220,
                                  v_fp: 12'd5, v_sync: 12'd5};
        endcase
        return cfg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/colorbar_mode_sequencer_rom.sv
`default_nettype none
// ============================================================================
//  Module      : mode_preset_rom
//  Description : Registered lookup of the timing preset for a mode. The
//                stored configuration only changes on i_load, so the
//                generator sees a stable config between mode switches.
//  Revision    : 1.0 - initial release
// ============================================================================
module mode_preset_rom
    import colorbar_mode_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [1:0]  i_mode,
    output timing_cfg_t o_cfg
);

    timing_cfg_t r_cfg_q;
    timing_cfg_t w_cfg_d;

    // Next config: new preset on load, otherwise hold
    always_comb begin
        w_cfg_d = r_cfg_q;
        if (i_load) begin
            w_cfg_d = preset_cfg(i_mode);
        end
    end

    // Config register, resets to the 720p preset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg_q <= preset_cfg(c_mode_720p);
        end else begin
            r_cfg_q <= w_cfg_d;
        end
    end

    assign o_cfg = r_cfg_q;

endmodule
`default_nettype wire

// File: rtl/colorbar_mode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : colorbar_mode_sequencer
//  Description : Selects a video timing preset for the colour-bar generator,
//                applies mode changes (host request or auto-cycle) only at a
//                frame boundary, holds the generator in reset during each
//                change and counts completed frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module colorbar_mode_sequencer
    import colorbar_mode_pkg::*;
#(
    parameter int RST_CYCLES      = 16,
    parameter int FRAMES_PER_MODE = 60,
    parameter int CFG_W           = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             auto_cycle,
    input  logic             req_valid,
    input  logic [1:0]       req_mode,
    output logic             req_ready,
    input  logic             fv_in,
    output logic             gen_rst,
    output logic [CFG_W-1:0] h_active,
    output logic [CFG_W-1:0] h_total,
    output logic [CFG_W-1:0] v_active,
    output logic [CFG_W-1:0] v_total,
    output logic [CFG_W-1:0] h_fp,
    output logic [CFG_W-1:0] h_sync,
    output logic [CFG_W-1:0] h_bp,
    output logic [CFG_W-1:0] v_fp,
    output logic [CFG_W-1:0] v_sync,
    output logic [1:0]       cur_mode,
    output logic [15:0]      frame_cnt,
    output logic             busy,
    output logic             err
);

    localparam int c_rst_cnt_w = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int c_fim_w     = $clog2(FRAMES_PER_MODE) + 1;
    localparam logic [c_rst_cnt_w-1:0] c_rst_last = c_rst_cnt_w'(RST_CYCLES - 1);
    localparam logic [c_fim_w-1:0]     c_fim_last = c_fim_w'(FRAMES_PER_MODE - 1);

    state_t                 r_state_q,     w_state_d;
    logic [1:0]             r_pending_q,   w_pending_d;
    logic [1:0]             r_cur_mode_q,  w_cur_mode_d;
    logic [c_rst_cnt_w-1:0] r_rst_cnt_q,   w_rst_cnt_d;
    logic [c_fim_w-1:0]     r_fim_q,       w_fim_d;
    logic [15:0]            r_frame_cnt_q, w_frame_cnt_d;
    logic                   r_fv_d_q;
    logic                   r_gen_rst_q,   w_gen_rst_d;
    logic                   r_busy_q,      w_busy_d;
    logic                   r_err_q,       w_err_d;

    logic                   w_frame_end;
    logic                   w_accept;
    logic                   w_load;
    logic [1:0]             w_next_auto;
    timing_cfg_t            w_cfg;

    assign w_frame_end = r_fv_d_q & ~fv_in;
    assign req_ready   = (r_state_q == RUN);
    assign w_accept    = req_valid & req_ready;
    // Preset and cur_mode are latched together in the first SWITCH cycle
    assign w_load      = (r_state_q == SWITCH) && (r_rst_cnt_q == '0);
    assign w_next_auto = (r_cur_mode_q == c_mode_480p) ? c_mode_720p
                                                       : r_cur_mode_q + 2'd1;

    // Next-state and datapath update for the sequencer
    always_comb begin
        w_state_d     = r_state_q;
        w_pending_d   = r_pending_q;
        w_rst_cnt_d   = r_rst_cnt_q;
        w_fim_d       = r_fim_q;
        w_frame_cnt_d = r_frame_cnt_q;
        w_err_d       = 1'b0;
        w_cur_mode_d  = w_load ? r_pending_q : r_cur_mode_q;

        if (w_frame_end && (r_state_q == RUN || r_state_q == DRAIN)) begin
            w_frame_cnt_d = r_frame_cnt_q + 16'd1;
        end

        case (r_state_q)
            IDLE: begin
                if (enable) begin
                    w_state_d   = SWITCH;
                    w_pending_d = r_cur_mode_q;
                    w_rst_cnt_d = '0;
                end
            end
            SWITCH: begin
                if (r_rst_cnt_q == c_rst_last) begin
                    w_state_d = RUN;
                    w_fim_d   = '0;
                end else begin
                    w_rst_cnt_d = r_rst_cnt_q + c_rst_cnt_w'(1);
                end
            end
            RUN: begin
                if (w_frame_end && (r_fim_q < c_fim_last)) begin
                    w_fim_d = r_fim_q + c_fim_w'(1);
                end
                // A legal host request takes priority over the auto-cycle step
                if (w_accept && (req_mode != c_mode_illegal)) begin
                    w_state_d   = DRAIN;
                    w_pending_d = req_mode;
                end else begin
                    w_err_d = w_accept;
                    if (auto_cycle && w_frame_end && (r_fim_q >= c_fim_last)) begin
                        w_state_d   = SWITCH;
                        w_pending_d = w_next_auto;
                        w_rst_cnt_d = '0;
                    end
                end
            end
            DRAIN: begin
                if (!r_fv_d_q) begin
                    w_state_d   = SWITCH;
                    w_rst_cnt_d = '0;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase

        // Disabling drops any pending change and parks the generator in reset
        if (!enable) begin
            w_state_d   = IDLE;
            w_pending_d = r_cur_mode_q;
            w_err_d     = 1'b0;
        end

        w_gen_rst_d = (w_state_d == IDLE) || (w_state_d == SWITCH);
        w_busy_d    = (w_state_d == DRAIN) || (w_state_d == SWITCH);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= IDLE;
            r_pending_q   <= c_mode_720p;
            r_cur_mode_q  <= c_mode_720p;
            r_rst_cnt_q   <= '0;
            r_fim_q       <= '0;
            r_frame_cnt_q <= 16'd0;
            r_fv_d_q      <= 1'b0;
            r_gen_rst_q   <= 1'b1;
            r_busy_q      <= 1'b0;
            r_err_q       <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_pending_q   <= w_pending_d;
            r_cur_mode_q  <= w_cur_mode_d;
            r_rst_cnt_q   <= w_rst_cnt_d;
            r_fim_q       <= w_fim_d;
            r_frame_cnt_q <= w_frame_cnt_d;
            r_fv_d_q      <= fv_in;
            r_gen_rst_q   <= w_gen_rst_d;
            r_busy_q      <= w_busy_d;
            r_err_q       <= w_err_d;
        end
    end

    mode_preset_rom u_rom (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_mode (r_pending_q),
        .o_cfg  (w_cfg)
    );

    assign h_active  = CFG_W'(w_cfg.h_active);
    assign h_total   = CFG_W'(w_cfg.h_total);
    assign v_active  = CFG_W'(w_cfg.v_active);
    assign v_total   = CFG_W'(w_cfg.v_total);
    assign h_fp      = CFG_W'(w_cfg.h_fp);
    assign h_sync    = CFG_W'(w_cfg.h_sync);
    assign h_bp      = CFG_W'(w_cfg.h_bp);
    assign v_fp      = CFG_W'(w_cfg.v_fp);
    assign v_sync    = CFG_W'(w_cfg.v_sync);
    assign cur_mode  = r_cur_mode_q;
    assign frame_cnt = r_frame_cnt_q;
    assign gen_rst   = r_gen_rst_q;
    assign busy      = r_busy_q;
    assign err       = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_colorbar_mode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_colorbar_mode_sequencer
//  Description : Directed self-checking bench for colorbar_mode_sequencer
//                (RST_CYCLES=16, FRAMES_PER_MODE=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_colorbar_mode_sequencer;

    localparam int RST_CYCLES      = 16;
    localparam int FRAMES_PER_MODE = 2;
    localparam int CFG_W           = 12;

    logic             clk = 1'b0;
    logic             rst, enable, auto_cycle, req_valid, fv_in;
    logic [1:0]       req_mode;
    logic             req_ready, gen_rst, busy, err;
    logic [CFG_W-1:0] h_active, h_total, v_active, v_total;
    logic [CFG_W-1:0] h_fp, h_sync, h_bp, v_fp, v_sync;
    logic [1:0]       cur_mode;
    logic [15:0]      frame_cnt;

    int checks = 0;
    int errors = 0;

    colorbar_mode_sequencer #(
        .RST_CYCLES      (RST_CYCLES),
        .FRAMES_PER_MODE (FRAMES_PER_MODE),
        .CFG_W           (CFG_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .auto_cycle (auto_cycle),
        .req_valid  (req_valid),
        .req_mode   (req_mode),
        .req_ready  (req_ready),
        .fv_in      (fv_in),
        .gen_rst    (gen_rst),
        .h_active   (h_active),
        .h_total    (h_total),
        .v_active   (v_active),
        .v_total    (v_total),
        .h_fp       (h_fp),
        .h_sync     (h_sync),
        .h_bp       (h_bp),
        .v_fp       (v_fp),
        .v_sync     (v_sync),
        .cur_mode   (cur_mode),
        .frame_cnt  (frame_cnt),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called in the first SWITCH cycle; counts cycles until gen_rst falls
    task automatic wait_switch(input string tag);
        int n;
        n = 0;
        while (gen_rst === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check(tag, n, RST_CYCLES);
    endtask

    // One frame: two active cycles, then the falling edge of fv_in
    task automatic frame();
        fv_in = 1'b1;
        tick();
        tick();
        fv_in = 1'b0;
        tick();
    endtask

    task automatic check_cfg(input string tag, input int ha, input int ht, input int va,
                             input int vt, input int hfp, input int hs, input int hbp,
                             input int vfp, input int vs);
        check({tag, "_h_active"}, 32'(h_active), ha);
        check({tag, "_h_total"},  32'(h_total),  ht);
        check({tag, "_v_active"}, 32'(v_active), va);
        check({tag, "_v_total"},  32'(v_total),  vt);
        check({tag, "_h_fp"},     32'(h_fp),     hfp);
        check({tag, "_h_sync"},   32'(h_sync),   hs);
        check({tag, "_h_bp"},     32'(h_bp),     hbp);
        check({tag, "_v_fp"},     32'(v_fp),     vfp);
        check({tag, "_v_sync"},   32'(v_sync),   vs);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; enable = 1'b0; auto_cycle = 1'b0;
        req_valid = 1'b0; req_mode = 2'd0; fv_in = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_gen_rst",   32'(gen_rst),   1);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_err",       32'(err),       0);
        check("rst_busy",      32'(busy),      0);
        check("rst_cur_mode",  32'(cur_mode),  0);
        check("rst_frame_cnt", 32'(frame_cnt), 0);
        check_cfg("rst", 1280, 1650, 720, 750, 110, 40, 220, 5, 5);

        // Enable: 16-cycle generator reset, then RUN in mode 0
        rst = 1'b0;
        enable = 1'b1;
        tick();
        check("en_busy", 32'(busy), 1);
        wait_switch("en_rst_len");
        check("en_req_ready", 32'(req_ready), 1);
        check("en_busy_low",  32'(busy),      0);
        check("en_cur_mode",  32'(cur_mode),  0);
        check_cfg("m0", 1280, 1650, 720, 750, 110, 40, 220, 5, 5);

        // Mid-frame request for mode 1 waits for the frame to end
        fv_in = 1'b1;
        tick();
        tick();
        req_valid = 1'b1; req_mode = 2'd1;
        check("mf_ready_before", 32'(req_ready), 1);
        tick();
        req_valid = 1'b0;
        check("mf_ready_drop", 32'(req_ready), 0);
        check("mf_busy",       32'(busy),      1);
        check("mf_gen_rst",    32'(gen_rst),   0);
        tick();
        tick();
        check("mf_hold_busy",     32'(busy),     1);
        check("mf_hold_h_active", 32'(h_active), 1280);
        check("mf_hold_cur_mode", 32'(cur_mode), 0);
        fv_in = 1'b0;
        tick();
        check("mf_frame_cnt",   32'(frame_cnt), 1);
        check("mf_drain_rst",   32'(gen_rst),   0);
        tick();
        check("mf_switch_rst",  32'(gen_rst),   1);
        wait_switch("mf_rst_len");
        check("mf_cur_mode",    32'(cur_mode),  1);
        check_cfg("m1", 1920, 2200, 1080, 1125, 88, 44, 148, 4, 5);
        check("mf_frame_cnt2",  32'(frame_cnt), 1);

        // Illegal mode request: one-cycle err, nothing else changes
        req_valid = 1'b1; req_mode = 2'd3;
        tick();
        req_valid = 1'b0;
        check("ill_err",       32'(err),       1);
        check("ill_ready",     32'(req_ready), 1);
        check("ill_gen_rst",   32'(gen_rst),   0);
        check("ill_busy",      32'(busy),      0);
        check("ill_cur_mode",  32'(cur_mode),  1);
        tick();
        check("ill_err_clear", 32'(err),       0);
        check("ill_ready2",    32'(req_ready), 1);
        check("ill_h_active",  32'(h_active),  1920);

        // Auto-cycle every two frames: 1 -> 2 -> 0
        auto_cycle = 1'b1;
        frame();
        check("ac1_run",       32'(req_ready), 1);
        check("ac1_frame_cnt", 32'(frame_cnt), 2);
        frame();
        check("ac2_gen_rst",   32'(gen_rst),   1);
        check("ac2_frame_cnt", 32'(frame_cnt), 3);
        wait_switch("ac2_rst_len");
        check("ac2_cur_mode",  32'(cur_mode),  2);
        check_cfg("m2", 640, 800, 480, 525, 16, 96, 48, 10, 2);
        frame();
        check("ac3_run",       32'(req_ready), 1);
        frame();
        check("ac4_frame_cnt", 32'(frame_cnt), 5);
        wait_switch("ac4_rst_len");
        check("ac4_cur_mode",  32'(cur_mode),  0);
        check("ac4_h_active",  32'(h_active),  1280);

        // Request for mode 2 on the auto-cycle trigger edge wins
        frame();
        check("tie_run", 32'(req_ready), 1);
        fv_in = 1'b1;
        tick();
        tick();
        fv_in = 1'b0;
        req_valid = 1'b1; req_mode = 2'd2;
        tick();
        req_valid = 1'b0;
        auto_cycle = 1'b0;
        check("tie_drain_busy",   32'(busy),      1);
        check("tie_drain_rst",    32'(gen_rst),   0);
        check("tie_frame_cnt",    32'(frame_cnt), 7);
        tick();
        check("tie_switch_rst",   32'(gen_rst),   1);
        wait_switch("tie_rst_len");
        check("tie_cur_mode",     32'(cur_mode),  2);
        check("tie_h_active",     32'(h_active),  640);

        // Enable dropped during SWITCH, then re-enabled
        req_valid = 1'b1; req_mode = 2'd1;
        tick();
        req_valid = 1'b0;
        tick();
        check("dis_switch_rst", 32'(gen_rst), 1);
        tick();
        tick();
        tick();
        enable = 1'b0;
        tick();
        check("dis_gen_rst",   32'(gen_rst),   1);
        check("dis_busy",      32'(busy),      0);
        check("dis_ready",     32'(req_ready), 0);
        check("dis_cur_mode",  32'(cur_mode),  1);
        check("dis_h_active",  32'(h_active),  1920);
        tick();
        tick();
        check("dis_idle_rst",  32'(gen_rst),   1);
        enable = 1'b1;
        tick();
        check("reen_busy", 32'(busy), 1);
        wait_switch("reen_rst_len");
        check("reen_cur_mode",  32'(cur_mode),  1);
        check("reen_v_total",   32'(v_total),   1125);
        check("reen_frame_cnt", 32'(frame_cnt), 7);

        // Frame counter wraps from 0xFFFF to 0
        force dut.w_frame_cnt_d = 16'hFFFF;
        tick();
        release dut.w_frame_cnt_d;
        check("wrap_preload", 32'(frame_cnt), 32'hFFFF);
        frame();
        check("wrap_zero",    32'(frame_cnt), 0);

        // Reset mid-operation returns outputs to reset values
        rst = 1'b1;
        tick();
        check("mrst_gen_rst",   32'(gen_rst),   1);
        check("mrst_ready",     32'(req_ready), 0);
        check("mrst_busy",      32'(busy),      0);
        check("mrst_cur_mode",  32'(cur_mode),  0);
        check("mrst_h_active",  32'(h_active),  1280);
        check("mrst_frame_cnt", 32'(frame_cnt), 0);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
